// File: rtl/text_pixel_renderer.sv
// Text-mode renderer: an 80x30 character RAM written at a hardware cursor from a valid/ready
// character stream, plus a fixed 4-clock pixel pipeline that looks glyphs up in an external font ROM.
module text_pixel_renderer #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] counter_x,
    input  logic [9:0] counter_y,
    input  logic       in_display_select,
    input  logic       char_valid,
    input  logic [7:0] char_code,
    output logic       char_ready,
    input  logic       clear_req,
    output logic [7:0] font_code,
    output logic [3:0] font_row,
    input  logic [7:0] font_bits,
    output logic [6:0] cursor_x,
    output logic [4:0] cursor_y,
    output logic       busy,
    output logic       pixel_on
);

    localparam int              CELLS      = COLS * ROWS;
    localparam logic [11:0]     LAST_ADDR  = 12'(CELLS - 1);
    localparam logic [6:0]      LAST_COL   = 7'(COLS - 1);
    localparam logic [4:0]      LAST_ROW   = 5'(ROWS - 1);
    localparam int              FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0]   LAST_FRAME = FW'(BLINK_FRAMES - 1);
    localparam logic [7:0]      CODE_CR    = 8'h0D;
    localparam logic [7:0]      CODE_BS    = 8'h08;
    localparam logic [7:0]      CODE_SPACE = 8'h20;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] clr_addr_q, clr_addr_d;
    logic [6:0]  cur_x_q, cur_x_d;
    logic [4:0]  cur_y_q, cur_y_d;
    logic [7:0]  char_q, char_d;

    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  ram [CELLS];

    logic [6:0]  e1_col_q, e1_col_d;
    logic [4:0]  e1_row_q, e1_row_d;
    logic [3:0]  e1_grow_q, e1_grow_d;
    logic [2:0]  e1_bit_q, e1_bit_d;
    logic        e1_en_q, e1_en_d;
    logic [11:0] rd_addr;
    logic [7:0]  font_code_q;
    logic [3:0]  font_row_q, font_row_d;
    logic [2:0]  e2_bit_q, e2_bit_d;
    logic        e2_en_q, e2_en_d;
    logic        e2_hit_q, e2_hit_d;
    logic [2:0]  e3_bit_q, e3_bit_d;
    logic        e3_en_q, e3_en_d;
    logic        e3_ul_q, e3_ul_d;
    logic        pixel_on_q, pixel_on_d;

    logic          frame_tick;
    logic [FW-1:0] frame_q, frame_d;
    logic          blink_q, blink_d;

    function automatic logic [11:0] cell_addr(input logic [6:0] x, input logic [4:0] y);
        return 12'(y) * 12'(COLS) + 12'(x);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // clear_req takes priority over a character offered in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR: if (clr_addr_q == LAST_ADDR) state_d = IDLE;
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                end else if (char_valid) begin
                    state_d = WRITE;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        busy       = (state_q == CLEAR);
        char_ready = (state_q == IDLE) && !clear_req;
    end

    // Backspace writes the blank at the cursor position after stepping back.
    always_comb begin
        clr_addr_d = clr_addr_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        char_d     = char_q;
        wr_en      = 1'b0;
        wr_addr    = cell_addr(cur_x_q, cur_y_q);
        wr_data    = char_q;
        case (state_q)
            CLEAR: begin
                wr_en      = 1'b1;
                wr_addr    = clr_addr_q;
                wr_data    = CODE_SPACE;
                clr_addr_d = clr_addr_q + 12'd1;
            end
            IDLE: begin
                if (clear_req) begin
                    clr_addr_d = 12'd0;
                    cur_x_d    = 7'd0;
                    cur_y_d    = 5'd0;
                end else if (char_valid) begin
                    char_d = char_code;
                end
            end
            WRITE: begin
                case (char_q)
                    CODE_CR: begin
                        cur_x_d = 7'd0;
                        cur_y_d = (cur_y_q == LAST_ROW) ? 5'd0 : cur_y_q + 5'd1;
                    end
                    CODE_BS: begin
                        if (cur_x_q != 7'd0) begin
                            cur_x_d = cur_x_q - 7'd1;
                        end else if (cur_y_q != 5'd0) begin
                            cur_x_d = LAST_COL;
                            cur_y_d = cur_y_q - 5'd1;
                        end
                        wr_en   = 1'b1;
                        wr_addr = cell_addr(cur_x_d, cur_y_d);
                        wr_data = CODE_SPACE;
                    end
                    default: begin
                        wr_en = 1'b1;
                        if (cur_x_q == LAST_COL) begin
                            cur_x_d = 7'd0;
                            cur_y_d = (cur_y_q == LAST_ROW) ? 5'd0 : cur_y_q + 5'd1;
                        end else begin
                            cur_x_d = cur_x_q + 7'd1;
                        end
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_addr_q <= 12'd0;
            cur_x_q    <= 7'd0;
            cur_y_q    <= 5'd0;
            char_q     <= 8'd0;
        end else begin
            clr_addr_q <= clr_addr_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            char_q     <= char_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_addr] <= wr_data;
        end
    end

    // Rows 30-31 of the counter space fall past the RAM; those pixels are never enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            font_code_q <= 8'd0;
        end else if (rd_addr < 12'(CELLS)) begin
            font_code_q <= ram[rd_addr];
        end else begin
            font_code_q <= CODE_SPACE;
        end
    end

    always_comb begin
        frame_tick = (counter_x == 10'd0) && (counter_y == 10'd0);
        frame_d    = frame_q;
        blink_d    = blink_q;
        if (frame_tick) begin
            if (frame_q == LAST_FRAME) begin
                frame_d = '0;
                blink_d = !blink_q;
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end
    end

    always_comb begin
        e1_col_d   = counter_x[9:3];
        e1_row_d   = counter_y[8:4];
        e1_grow_d  = counter_y[3:0];
        e1_bit_d   = counter_x[2:0];
        e1_en_d    = in_display_select;
        rd_addr    = cell_addr(e1_col_q, e1_row_q);
        font_row_d = e1_grow_q;
        e2_bit_d   = e1_bit_q;
        e2_en_d    = e1_en_q;
        e2_hit_d   = (e1_col_q == cur_x_q) && (e1_row_q == cur_y_q);
        e3_bit_d   = e2_bit_q;
        e3_en_d    = e2_en_q;
        e3_ul_d    = e2_hit_q && (font_row_q >= 4'd14);
        pixel_on_d = e3_en_q & (font_bits[3'd7 - e3_bit_q] ^ (e3_ul_q & blink_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1_col_q   <= 7'd0;
            e1_row_q   <= 5'd0;
            e1_grow_q  <= 4'd0;
            e1_bit_q   <= 3'd0;
            e1_en_q    <= 1'b0;
            font_row_q <= 4'd0;
            e2_bit_q   <= 3'd0;
            e2_en_q    <= 1'b0;
            e2_hit_q   <= 1'b0;
            e3_bit_q   <= 3'd0;
            e3_en_q    <= 1'b0;
            e3_ul_q    <= 1'b0;
            pixel_on_q <= 1'b0;
            frame_q    <= '0;
            blink_q    <= 1'b0;
        end else begin
            e1_col_q   <= e1_col_d;
            e1_row_q   <= e1_row_d;
            e1_grow_q  <= e1_grow_d;
            e1_bit_q   <= e1_bit_d;
            e1_en_q    <= e1_en_d;
            font_row_q <= font_row_d;
            e2_bit_q   <= e2_bit_d;
            e2_en_q    <= e2_en_d;
            e2_hit_q   <= e2_hit_d;
            e3_bit_q   <= e3_bit_d;
            e3_en_q    <= e3_en_d;
            e3_ul_q    <= e3_ul_d;
            pixel_on_q <= pixel_on_d;
            frame_q    <= frame_d;
            blink_q    <= blink_d;
        end
    end

    assign font_code = font_code_q;
    assign font_row  = font_row_q;
    assign cursor_x  = cur_x_q;
    assign cursor_y  = cur_y_q;
    assign pixel_on  = pixel_on_q;

endmodule
